// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX, MEM/WB and EX/MEM signal bundle around the execute stage
interface execute_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in, alu_src_in;
  logic [1:0]      alu_op_in;
  logic [XLEN-1:0] pc_in, instruction_in, immediate_in, reg_read_data1_in, reg_read_data2_in;
  logic [4:0]      reg_rs_1_in, reg_rs_2_in, reg_rd_in;
  logic            memwb_reg_write;
  logic [4:0]      memwb_rd;
  logic [XLEN-1:0] memwb_data;
  logic            md_stall;
  logic            reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, branch_taken_out;
  logic [XLEN-1:0] alu_result_out, store_data_out, branch_target_out;
  logic [4:0]      rd_out;

  modport master (
    output flush, reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in, alu_src_in,
    output alu_op_in, pc_in, instruction_in, immediate_in, reg_read_data1_in, reg_read_data2_in,
    output reg_rs_1_in, reg_rs_2_in, reg_rd_in, memwb_reg_write, memwb_rd, memwb_data,
    input  md_stall, reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, branch_taken_out,
    input  alu_result_out, store_data_out, branch_target_out, rd_out
  );

  modport slave (
    input  flush, reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in, branch_in, alu_src_in,
    input  alu_op_in, pc_in, instruction_in, immediate_in, reg_read_data1_in, reg_read_data2_in,
    input  reg_rs_1_in, reg_rs_2_in, reg_rd_in, memwb_reg_write, memwb_rd, memwb_data,
    output md_stall, reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out, branch_taken_out,
    output alu_result_out, store_data_out, branch_target_out, rd_out
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32IM execute stage: forwarding, ALU, branch unit, iterative mul/div, EX/MEM register
module execute_stage #(
  parameter int XLEN = 32
) (
  input logic             clock,
  input logic             resetn,
  execute_stage_if.slave  ex
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t       state, state_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, quo, opb;
  logic [2:0]      md_funct3;
  logic            sign_a, sign_b, b_zero;

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result, md_result;
  logic [CW-1:0]   shamt;
  logic            branch_cond, is_mop;
  logic            unused_instr_bits;

  assign funct3 = ex.instruction_in[14:12];
  assign funct7 = ex.instruction_in[31:25];
  assign unused_instr_bits = ^{ex.instruction_in[24:15], ex.instruction_in[11:7]};

  // EX/MEM result wins over MEM/WB; x0 is never forwarded
  always_comb begin
    fwd_a = ex.reg_read_data1_in;
    if (ex.reg_rs_1_in != 5'd0 && ex.reg_write_out && ex.rd_out == ex.reg_rs_1_in)
      fwd_a = ex.alu_result_out;
    else if (ex.memwb_reg_write && ex.memwb_rd == ex.reg_rs_1_in && ex.reg_rs_1_in != 5'd0)
      fwd_a = ex.memwb_data;
  end

  always_comb begin
    fwd_b = ex.reg_read_data2_in;
    if (ex.reg_rs_2_in != 5'd0 && ex.reg_write_out && ex.rd_out == ex.reg_rs_2_in)
      fwd_b = ex.alu_result_out;
    else if (ex.memwb_reg_write && ex.memwb_rd == ex.reg_rs_2_in && ex.reg_rs_2_in != 5'd0)
      fwd_b = ex.memwb_data;
  end

  assign op_b  = ex.alu_src_in ? ex.immediate_in : fwd_b;
  assign shamt = op_b[CW-1:0];

  always_comb begin
    alu_result = fwd_a + op_b;
    case (ex.alu_op_in)
      2'b00: alu_result = fwd_a + op_b;
      2'b01: alu_result = fwd_a - op_b;
      default: begin
        case (funct3)
          3'b000:  alu_result = (ex.alu_op_in == 2'b10 && funct7[5]) ? fwd_a - op_b : fwd_a + op_b;
          3'b001:  alu_result = fwd_a << shamt;
          3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
          3'b011:  alu_result = {{(XLEN-1){1'b0}}, fwd_a < op_b};
          3'b100:  alu_result = fwd_a ^ op_b;
          3'b101:  alu_result = funct7[5] ? XLEN'($signed(fwd_a) >>> shamt) : fwd_a >> shamt;
          3'b110:  alu_result = fwd_a | op_b;
          default: alu_result = fwd_a & op_b;
        endcase
      end
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_cond = (fwd_a == fwd_b);
      3'b001:  branch_cond = (fwd_a != fwd_b);
      3'b100:  branch_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  branch_cond = !($signed(fwd_a) < $signed(fwd_b));
      3'b110:  branch_cond = (fwd_a < fwd_b);
      3'b111:  branch_cond = !(fwd_a < fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign is_mop = (ex.instruction_in[6:0] == 7'b0110011) && (funct7 == 7'b0000001) &&
                  (ex.alu_op_in == 2'b10);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ex.md_stall = 1'b0;
    case (state)
      IDLE: if (is_mop) begin
        state_next  = BUSY;
        ex.md_stall = 1'b1;
      end
      BUSY: begin
        ex.md_stall = 1'b1;
        if (count == CW'(XLEN-1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (ex.flush) begin
      state_next  = IDLE;
      ex.md_stall = 1'b0;
    end
    if (!resetn) ex.md_stall = 1'b0;
  end

  // Mul and div share the {acc, quo} pair: acc starts at 0, quo holds |a|, opb holds |b|
  logic            a_signed, b_signed;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  end

  assign mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign div_shift = {acc, quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      acc       <= '0;
      quo       <= '0;
      opb       <= '0;
      md_funct3 <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
    end else if (state == IDLE && state_next == BUSY) begin
      count     <= '0;
      acc       <= '0;
      sign_a    <= a_signed & fwd_a[XLEN-1];
      sign_b    <= b_signed & fwd_b[XLEN-1];
      quo       <= (a_signed & fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
      opb       <= (b_signed & fwd_b[XLEN-1]) ? -fwd_b : fwd_b;
      b_zero    <= (fwd_b == '0);
      md_funct3 <= funct3;
    end else if (state == BUSY && !ex.flush) begin
      count <= count + CW'(1);
      if (md_funct3[2]) begin
        // restoring step: keep the difference only when it did not borrow
        if (!div_diff[XLEN]) begin
          acc <= div_diff[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b1};
        end else begin
          acc <= div_shift[XLEN-1:0];
          quo <= {quo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[XLEN:1];
        quo <= {mul_sum[0], quo[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  // Divide by zero keeps the remainder as the dividend; only the quotient is forced
  always_comb begin
    prod_s = (sign_a ^ sign_b) ? -{acc, quo} : {acc, quo};
    quot_s = b_zero ? {XLEN{1'b1}} : ((sign_a ^ sign_b) ? -quo : quo);
    rem_s  = sign_a ? -acc : acc;
    case (md_funct3)
      3'b000:                 md_result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_result = quot_s;
      default:                md_result = rem_s;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn || ex.flush || ex.md_stall) begin
      ex.reg_write_out     <= 1'b0;
      ex.mem_to_reg_out    <= 1'b0;
      ex.mem_read_out      <= 1'b0;
      ex.mem_write_out     <= 1'b0;
      ex.branch_taken_out  <= 1'b0;
      ex.alu_result_out    <= '0;
      ex.store_data_out    <= '0;
      ex.branch_target_out <= '0;
      ex.rd_out            <= '0;
    end else begin
      ex.reg_write_out     <= ex.reg_write_in & ~ex.branch_in;
      ex.mem_to_reg_out    <= ex.mem_to_reg_in;
      ex.mem_read_out      <= ex.mem_read_in;
      ex.mem_write_out     <= ex.mem_write_in;
      ex.branch_taken_out  <= ex.branch_in & branch_cond;
      ex.alu_result_out    <= (state == DONE) ? md_result : alu_result;
      ex.store_data_out    <= fwd_b;
      ex.branch_target_out <= ex.pc_in + ex.immediate_in;
      ex.rd_out            <= ex.reg_rd_in;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed-vector bench for execute_stage
module tb_execute_stage;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;

  execute_stage_if #(.XLEN(32)) bus ();
  execute_stage #(.XLEN(32)) dut (.clock(clock), .resetn(resetn), .ex(bus));

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    bus.reg_write_in      = 1'b0;
    bus.mem_to_reg_in     = 1'b0;
    bus.mem_read_in       = 1'b0;
    bus.mem_write_in      = 1'b0;
    bus.branch_in         = 1'b0;
    bus.alu_src_in        = 1'b0;
    bus.alu_op_in         = 2'b00;
    bus.pc_in             = '0;
    bus.instruction_in    = '0;
    bus.immediate_in      = '0;
    bus.reg_read_data1_in = '0;
    bus.reg_read_data2_in = '0;
    bus.reg_rs_1_in       = '0;
    bus.reg_rs_2_in       = '0;
    bus.reg_rd_in         = '0;
  endtask

  task automatic set_memwb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.memwb_reg_write = we;
    bus.memwb_rd        = rd;
    bus.memwb_data      = data;
  endtask

  task automatic drive_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2);
    nop();
    bus.instruction_in    = {f7, rs2, rs1, f3, rd, 7'b0110011};
    bus.alu_op_in         = 2'b10;
    bus.reg_write_in      = 1'b1;
    bus.reg_rs_1_in       = rs1;
    bus.reg_rs_2_in       = rs2;
    bus.reg_rd_in         = rd;
    bus.reg_read_data1_in = d1;
    bus.reg_read_data2_in = d2;
  endtask

  task automatic check_bubble(input string tag);
    check_eq({tag, " ctrl"}, 32'({bus.reg_write_out, bus.mem_to_reg_out, bus.mem_read_out,
                                   bus.mem_write_out, bus.branch_taken_out}), 32'd0);
    check_eq({tag, " data"}, bus.alu_result_out, 32'd0);
    check_eq({tag, " rd"}, 32'(bus.rd_out), 32'd0);
  endtask

  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    int bad;
    drive_r(7'b0000001, f3, 5'd1, 5'd2, 5'd10, a, b);
    #1;
    n = 0;
    bad = 0;
    while (bus.md_stall && n < 100) begin
      tick();
      n++;
      if (bus.reg_write_out || bus.mem_to_reg_out || bus.mem_read_out || bus.mem_write_out ||
          bus.branch_taken_out || bus.rd_out != 5'd0)
        bad++;
    end
    check_eq({tag, " stall_cycles"}, n, 33);
    check_eq({tag, " bubbles"}, bad, 0);
    tick();
    check_eq(tag, bus.alu_result_out, exp);
    check_eq({tag, " rd"}, 32'(bus.rd_out), 32'd10);
  endtask

  initial begin
    bus.flush = 1'b0;
    nop();
    set_memwb(1'b0, 5'd0, '0);
    repeat (2) tick();
    check_eq("reset md_stall", 32'(bus.md_stall), 32'd0);
    check_bubble("reset");
    check_eq("reset target", bus.branch_target_out, 32'd0);
    resetn = 1'b1;
    tick();

    drive_r(7'b0, 3'b000, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4);
    tick();
    check_eq("add x5", bus.alu_result_out, 32'd7);
    drive_r(7'b0, 3'b000, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0);
    tick();
    check_eq("exmem fwd", bus.alu_result_out, 32'd14);
    check_eq("exmem fwd store", bus.store_data_out, 32'd7);
    drive_r(7'b0, 3'b000, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4);
    tick();
    nop();
    tick();
    drive_r(7'b0, 3'b000, 5'd5, 5'd5, 5'd6, 32'd0, 32'd0);
    set_memwb(1'b1, 5'd5, 32'd7);
    tick();
    check_eq("memwb fwd", bus.alu_result_out, 32'd14);

    set_memwb(1'b0, 5'd0, '0);
    drive_r(7'b0, 3'b000, 5'd1, 5'd0, 5'd7, 32'd10, 32'd0);
    tick();
    drive_r(7'b0, 3'b000, 5'd7, 5'd0, 5'd8, 32'd99, 32'd0);
    set_memwb(1'b1, 5'd7, 32'd20);
    tick();
    check_eq("double hazard", bus.alu_result_out, 32'd10);
    set_memwb(1'b0, 5'd0, '0);
    drive_r(7'b0, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0);
    tick();
    drive_r(7'b0, 3'b000, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
    set_memwb(1'b1, 5'd0, 32'd5);
    tick();
    check_eq("x0 no fwd", bus.alu_result_out, 32'd0);
    set_memwb(1'b0, 5'd0, '0);

    drive_r(7'b0, 3'b100, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1);
    bus.instruction_in[6:0] = 7'b1100011;
    bus.alu_op_in = 2'b01;
    bus.reg_write_in = 1'b0;
    bus.branch_in = 1'b1;
    bus.pc_in = 32'h100;
    bus.immediate_in = 32'h20;
    tick();
    check_eq("blt taken", 32'(bus.branch_taken_out), 32'd1);
    check_eq("blt target", bus.branch_target_out, 32'h120);
    check_eq("blt no write", 32'(bus.reg_write_out), 32'd0);
    bus.instruction_in[14:12] = 3'b110;
    tick();
    check_eq("bltu taken", 32'(bus.branch_taken_out), 32'd0);
    check_eq("bltu target", bus.branch_target_out, 32'h120);

    run_mop("mul", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_mop("mulhu", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1);
    run_mop("div by 0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_mop("rem by 0", 3'b110, 32'd7, 32'd0, 32'd7);
    run_mop("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_mop("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_mop("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

    drive_r(7'b0000001, 3'b100, 5'd1, 5'd2, 5'd10, 32'd100, 32'd3);
    repeat (11) tick();
    check_eq("busy stall", 32'(bus.md_stall), 32'd1);
    bus.flush = 1'b1;
    #1;
    check_eq("flush stall drop", 32'(bus.md_stall), 32'd0);
    tick();
    check_bubble("flush");
    check_eq("flush beats start", 32'(bus.md_stall), 32'd0);
    bus.flush = 1'b0;
    nop();
    #1;
    check_eq("flush idle", 32'(bus.md_stall), 32'd0);
    run_mop("div after flush", 3'b101, 32'd100, 32'd3, 32'd33);

    drive_r(7'b0000001, 3'b100, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFF9, 32'd2);
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    check_eq("reset mid stall", 32'(bus.md_stall), 32'd0);
    check_bubble("reset mid");
    nop();
    tick();
    resetn = 1'b1;
    #1;
    check_eq("reset idle", 32'(bus.md_stall), 32'd0);
    tick();
    check_bubble("after reset");
    run_mop("div after reset", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
